mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage that consumes the EX/MEM outputs of the execute-stage ALU (result, effective address, memory control bits, destination register) and performs the data-memory access. It drives a variable-latency req/ack data-memory port, stalls the execute stage while an access is outstanding, and presents registered MEM/WB results to writeback. It also flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT, 15: max cycles dmem_req may stay high without dmem_ack before abort (range 1..255)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_2_mem  in  1  EX/MEM slot holds a valid instruction
- rd  in  32  ALU result (non-memory ops)
- A  in  32  effective address (load/store)
- store_data_2_mem  in  32  store data (rt value)
- mem_read_2_mem  in  1  load
- mem_write_2_mem  in  1  store
- mem_to_reg_2_mem  in  1  writeback selects memory data
- reg_write_2_mem  in  1  instruction writes a register
- rd_add_value_2_mem  in  5  destination register address
- stall_2_ex  out  1  EX must hold its outputs this cycle
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  write data
- dmem_ack  in  1  access complete (read data valid same cycle)
- dmem_rdata  in  32  read data
- wb_valid  out  1  MEM/WB slot valid (one-cycle pulse per instruction)
- wb_data  out  32  writeback data
- wb_rd_add  out  5  writeback register address
- wb_reg_write  out  1  register write enable
- err  out  3  sticky flags: [0] misaligned, [1] timeout, [2] illegal (read and write both set)

## Operation
- States: IDLE, WAIT.
- IDLE, valid_2_mem=0: wb_valid<=0, stay IDLE.
- IDLE, valid, no memory op: wb_data<=rd, wb_rd_add<=rd_add_value_2_mem, wb_reg_write<=reg_write_2_mem, wb_valid<=1; stay IDLE.
- IDLE, valid, read and write both set: err[2]<=1; no access; wb_valid<=1 with wb_reg_write<=0.
- IDLE, valid, memory op, A[1:0]!=0: err[0]<=1; no access; wb_valid<=1 with wb_reg_write<=0.
- IDLE, valid, legal aligned op: register dmem_addr<=A, dmem_we<=mem_write_2_mem, dmem_wdata<=store_data_2_mem, dmem_req<=1, latch rd, rd_add, reg_write, mem_to_reg, clear timeout counter; go WAIT; wb_valid<=0.
- WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata held stable; inputs ignored; counter increments each cycle without ack.
- WAIT, dmem_ack=1: dmem_req<=0; wb_data<= mem_to_reg ? dmem_rdata : latched rd; wb_rd_add, wb_reg_write from latch (store forces wb_reg_write=0); wb_valid<=1; go IDLE.
- WAIT, no ack and counter reaches TIMEOUT: dmem_req<=0, err[1]<=1, wb_valid<=1 with wb_reg_write<=0; go IDLE. Ack arriving on the same edge as timeout wins (normal completion, no error).
- wb_reg_write is also forced 0 when wb_rd_add==0.
- err bits set only, cleared only by reset.

## Timing
- Reset (reset=0, immediate): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_data=0, wb_rd_add=0, wb_reg_write=0, err=0, counter=0. Reset during WAIT abandons the access at once; dmem_req drops asynchronously.
- stall_2_ex = (state==WAIT), combinational from state register; EX holds its outputs while high.
- Non-memory op: accepted at edge T0, wb outputs valid after T0 (1-cycle latency), no stall.
- Memory op: accepted at T0, dmem_req high from T0; ack sampled at edge Tk (k>=1); wb outputs valid after Tk; stall high for k cycles. Zero-wait memory (ack at first sample): 2-cycle latency, 1 stall cycle.
- Timeout: abort at edge where TIMEOUT cycles have elapsed since T0 without ack.
- New instruction accepted on the same edge WAIT returns to IDLE is not allowed; first acceptance is the following edge.

## Test plan
- Non-memory op rd=0x0000_0005, rd_add=3, reg_write=1 -> next cycle wb_valid=1, wb_data=5, wb_rd_add=3, wb_reg_write=1, stall_2_ex never high.
- Load A=0x100, mem_to_reg=1, ack after 3 cycles with rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, addr 0x100, we=0, stall high 3 cycles, then wb_data=0xDEADBEEF.
- Store A=0x104, data 0x1234 with immediate ack -> dmem_we=1, wdata=0x1234 for 1 cycle, wb_valid=1 with wb_reg_write=0.
- Load A=0x102 -> no dmem_req, err=3'b001, wb_reg_write=0; read+write both set -> err[2]=1.
- Load, ack never arrives, TIMEOUT=15 -> req drops after 15 cycles, err[1]=1; following op proceeds normally.
- Reset asserted in WAIT -> dmem_req and stall_2_ex drop immediately, all outputs zero, err=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs the data-memory access for loads and stores
// over a variable-latency req/ack port, stalls EX while an access is
// outstanding, and registers the MEM/WB results. Misaligned, illegal and
// timed-out accesses are recorded in sticky error flags.
module mem_access_stage #(
  parameter int TIMEOUT = 15  // 1..255 cycles of req without ack before abort
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_2_mem,
  input  logic [31:0] rd,
  input  logic [31:0] A,
  input  logic [31:0] store_data_2_mem,
  input  logic        mem_read_2_mem,
  input  logic        mem_write_2_mem,
  input  logic        mem_to_reg_2_mem,
  input  logic        reg_write_2_mem,
  input  logic [4:0]  rd_add_value_2_mem,
  output logic        stall_2_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_add,
  output logic        wb_reg_write,
  output logic [2:0]  err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Counter value seen on the cycle whose edge completes TIMEOUT waiting cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_add_q, wb_rd_add_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] lat_rd_q, lat_rd_d;
  logic [4:0]  lat_rd_add_q, lat_rd_add_d;
  logic        lat_reg_write_q, lat_reg_write_d;
  logic        lat_m2r_q, lat_m2r_d;

  // Next-state and next-output logic for the IDLE/WAIT access controller.
  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    wb_valid_d      = 1'b0;
    wb_data_d       = wb_data_q;
    wb_rd_add_d     = wb_rd_add_q;
    wb_reg_write_d  = wb_reg_write_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    lat_rd_d        = lat_rd_q;
    lat_rd_add_d    = lat_rd_add_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_m2r_d       = lat_m2r_q;

    case (state_q)
      IDLE: begin
        if (valid_2_mem) begin
          if (mem_read_2_mem && mem_write_2_mem) begin
            // Illegal: retire without access and without a register write.
            err_d[2]       = 1'b1;
            wb_valid_d     = 1'b1;
            wb_data_d      = rd;
            wb_rd_add_d    = rd_add_value_2_mem;
            wb_reg_write_d = 1'b0;
          end else if (mem_read_2_mem || mem_write_2_mem) begin
            if (A[1:0] != 2'b00) begin
              err_d[0]       = 1'b1;
              wb_valid_d     = 1'b1;
              wb_data_d      = rd;
              wb_rd_add_d    = rd_add_value_2_mem;
              wb_reg_write_d = 1'b0;
            end else begin
              dmem_req_d      = 1'b1;
              dmem_we_d       = mem_write_2_mem;
              dmem_addr_d     = A;
              dmem_wdata_d    = store_data_2_mem;
              lat_rd_d        = rd;
              lat_rd_add_d    = rd_add_value_2_mem;
              // A store never writes the register file.
              lat_reg_write_d = reg_write_2_mem && !mem_write_2_mem;
              lat_m2r_d       = mem_to_reg_2_mem;
              cnt_d           = 8'd0;
              state_d         = WAIT;
            end
          end else begin
            wb_valid_d     = 1'b1;
            wb_data_d      = rd;
            wb_rd_add_d    = rd_add_value_2_mem;
            wb_reg_write_d = reg_write_2_mem && (rd_add_value_2_mem != 5'd0);
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          // Ack takes priority over a timeout landing on the same edge.
          dmem_req_d     = 1'b0;
          wb_valid_d     = 1'b1;
          wb_data_d      = lat_m2r_q ? dmem_rdata : lat_rd_q;
          wb_rd_add_d    = lat_rd_add_q;
          wb_reg_write_d = lat_reg_write_q && (lat_rd_add_q != 5'd0);
          state_d        = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d     = 1'b0;
          err_d[1]       = 1'b1;
          wb_valid_d     = 1'b1;
          wb_data_d      = lat_rd_q;
          wb_rd_add_d    = lat_rd_add_q;
          wb_reg_write_d = 1'b0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= 32'd0;
      dmem_wdata_q    <= 32'd0;
      wb_valid_q      <= 1'b0;
      wb_data_q       <= 32'd0;
      wb_rd_add_q     <= 5'd0;
      wb_reg_write_q  <= 1'b0;
      err_q           <= 3'd0;
      cnt_q           <= 8'd0;
      lat_rd_q        <= 32'd0;
      lat_rd_add_q    <= 5'd0;
      lat_reg_write_q <= 1'b0;
      lat_m2r_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_data_q       <= wb_data_d;
      wb_rd_add_q     <= wb_rd_add_d;
      wb_reg_write_q  <= wb_reg_write_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      lat_rd_q        <= lat_rd_d;
      lat_rd_add_q    <= lat_rd_add_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_m2r_q       <= lat_m2r_d;
    end
  end

  assign stall_2_ex   = (state_q == WAIT);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd_add    = wb_rd_add_q;
  assign wb_reg_write = wb_reg_write_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: non-memory op, load with wait
// states, zero-wait store, misaligned/illegal ops, timeout, ack on the
// timeout edge, and asynchronous reset during an outstanding access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_2_mem = 1'b0;
  logic [31:0] rd = '0;
  logic [31:0] A = '0;
  logic [31:0] store_data_2_mem = '0;
  logic        mem_read_2_mem = 1'b0;
  logic        mem_write_2_mem = 1'b0;
  logic        mem_to_reg_2_mem = 1'b0;
  logic        reg_write_2_mem = 1'b0;
  logic [4:0]  rd_add_value_2_mem = '0;
  logic        stall_2_ex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_add;
  logic        wb_reg_write;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int req_cnt;

  mem_access_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .valid_2_mem(valid_2_mem), .rd(rd), .A(A),
    .store_data_2_mem(store_data_2_mem), .mem_read_2_mem(mem_read_2_mem),
    .mem_write_2_mem(mem_write_2_mem), .mem_to_reg_2_mem(mem_to_reg_2_mem),
    .reg_write_2_mem(reg_write_2_mem), .rd_add_value_2_mem(rd_add_value_2_mem),
    .stall_2_ex(stall_2_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd_add(wb_rd_add), .wb_reg_write(wb_reg_write), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [31:0] a,
                       input logic [31:0] sd, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic [4:0] ra);
    valid_2_mem = v; rd = r; A = a; store_data_2_mem = sd;
    mem_read_2_mem = mr; mem_write_2_mem = mw; mem_to_reg_2_mem = m2r;
    reg_write_2_mem = rw; rd_add_value_2_mem = ra;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall_2_ex}, 32'd0);
    #20 reset = 1'b1;
    tick();

    // Non-memory op
    drive(1'b1, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_wb_data", wb_data, 32'h5);
    chk("alu_wb_rd_add", {27'd0, wb_rd_add}, 32'd3);
    chk("alu_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_stall", {31'd0, stall_2_ex}, 32'd0);
    chk("alu_req", {31'd0, dmem_req}, 32'd0);
    idle_in();
    tick();
    chk("alu_wb_pulse", {31'd0, wb_valid}, 32'd0);

    // Load with ack on the third sampling edge
    drive(1'b1, 32'h0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    tick();
    idle_in();
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_wb_valid_early", {31'd0, wb_valid}, 32'd0);
    stall_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall_2_ex) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      tick();
    end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("ld_stall_cycles", stall_cnt, 32'd3);
    chk("ld_req_cycles", req_cnt, 32'd3);
    chk("ld_req_after", {31'd0, dmem_req}, 32'd0);
    chk("ld_stall_after", {31'd0, stall_2_ex}, 32'd0);
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rd_add", {27'd0, wb_rd_add}, 32'd9);
    chk("ld_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);

    // Store with immediate ack
    drive(1'b1, 32'h0, 32'h104, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4);
    tick();
    idle_in();
    chk("st_req", {31'd0, dmem_req}, 32'd1);
    chk("st_we", {31'd0, dmem_we}, 32'd1);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_addr", dmem_addr, 32'h104);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("st_req_after", {31'd0, dmem_req}, 32'd0);
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

    // rd_add == 0 suppresses the register write
    drive(1'b1, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("r0_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

    // Misaligned load
    drive(1'b1, 32'h0, 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_err", {29'd0, err}, 32'h1);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("mis_stall", {31'd0, stall_2_ex}, 32'd0);

    // Illegal read+write
    drive(1'b1, 32'h0, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6);
    tick();
    idle_in();
    chk("ill_req", {31'd0, dmem_req}, 32'd0);
    chk("ill_err", {29'd0, err}, 32'h5);
    chk("ill_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

    // Load that never gets an ack
    drive(1'b1, 32'h0, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    idle_in();
    req_cnt = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      req_cnt++;
      tick();
    end
    chk("to_req_cycles", req_cnt, 32'd15);
    chk("to_req_after", {31'd0, dmem_req}, 32'd0);
    chk("to_err", {29'd0, err}, 32'h7);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

    // Following op proceeds normally
    drive(1'b1, 32'h0, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    tick();
    idle_in();
    chk("post_req", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    chk("post_wb_data", wb_data, 32'hCAFEF00D);
    chk("post_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);

    // Reset during WAIT
    drive(1'b1, 32'h0, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
    tick();
    idle_in();
    chk("rw_req_before", {31'd0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, stall_2_ex}, 32'd0);
    chk("rw_addr", dmem_addr, 32'd0);
    chk("rw_wb_data", wb_data, 32'd0);
    chk("rw_wb_rd_add", {27'd0, wb_rd_add}, 32'd0);
    chk("rw_err", {29'd0, err}, 32'd0);
    #3 reset = 1'b1;

    // Ack arriving on the timeout edge completes normally
    tick();
    drive(1'b1, 32'h0, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10);
    tick();
    idle_in();
    for (int i = 0; i < 14; i++) tick();
    chk("edge_req_pending", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0;
    chk("edge_wb_data", wb_data, 32'h0BADF00D);
    chk("edge_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("edge_err", {29'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
